mini_uart: RTL and testbench

- Memory-mapped 8N1 UART peripheral on a WISHBONE-style single-cycle slave bus.
- Has a transmit holding/shift path, a receive path, a status register, and independent programmable TX/RX baud divisors.
- Raises a level interrupt when a received byte is available.
- Sits on the CPU bridge, with txd/rxd going to the board serial pins.

---
 rtl/mini_uart.sv | 243 ++++++++++++++++++++++++
 tb/tb_mini_uart.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mini_uart.sv
// mini_uart: memory-mapped 8N1 UART on a single-cycle WISHBONE-style slave.
// Programmable TX/RX divisors, status register and an rx-data-ready interrupt.
module mini_uart #(
  parameter int DIV_RST = 434,
  parameter int DIV_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  off,
  input  logic [31:0] din,
  output logic [31:0] dout,
  input  logic        stb,
  input  logic        we,
  output logic        ack,
  input  logic        rxd,
  output logic        txd,
  output logic        IRQ_data_complete
);

  localparam logic [1:0] TX_IDLE  = 2'd0;
  localparam logic [1:0] TX_START = 2'd1;
  localparam logic [1:0] TX_DATA  = 2'd2;
  localparam logic [1:0] TX_STOP  = 2'd3;

  localparam logic [2:0] RX_IDLE  = 3'd0;
  localparam logic [2:0] RX_START = 3'd1;
  localparam logic [2:0] RX_DATA  = 3'd2;
  localparam logic [2:0] RX_STOP  = 3'd3;
  localparam logic [2:0] RX_WAIT  = 3'd4;

  localparam logic [DIV_W-1:0] DIV_INIT = DIV_W'(DIV_RST);

  logic             wr_en, rd_data;
  logic [DIV_W-1:0] divr_q, divr_d, divt_q, divt_d;

  logic [1:0]       tx_st_q, tx_st_d;
  logic [DIV_W-1:0] tx_cnt_q, tx_cnt_d, tx_div_q, tx_div_d;
  logic [2:0]       tx_bit_q, tx_bit_d;
  logic [7:0]       tx_sh_q, tx_sh_d;
  logic             txd_q, txd_d;
  logic [DIV_W:0]   tx_cnt_n;
  logic             tx_end;

  logic             rx_s1_q, rx_s2_q;
  logic [2:0]       rx_st_q, rx_st_d;
  logic [DIV_W-1:0] rx_cnt_q, rx_cnt_d, rx_div_q, rx_div_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_sh_q, rx_sh_d;
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             dr_q, dr_d, fe_q, fe_d;
  logic [DIV_W:0]   rx_cnt_n;
  logic             rx_end, rx_mid;

  logic [7:0]       lsr;
  logic             unused_din;

  assign wr_en   = stb & we;
  assign rd_data = stb & ~we & (off == 3'd0);
  assign ack     = stb;
  assign txd     = txd_q;
  assign IRQ_data_complete = dr_q;
  assign unused_din = ^din[31:DIV_W];

  assign lsr = {2'b00, (tx_st_q == TX_IDLE), 1'b0,
                fe_q, 2'b00, dr_q};

  always_comb begin
    dout = '0;
    if (stb) begin
      unique case (off)
        3'd0:    dout = {24'b0, rx_byte_q};
        3'd2:    dout = {24'b0, lsr};
        3'd3:    dout = 32'(divr_q);
        3'd4:    dout = 32'(divt_q);
        default: dout = '0;
      endcase
    end
  end

  always_comb begin
    divr_d = divr_q;
    divt_d = divt_q;
    if (wr_en && off == 3'd3) divr_d = din[DIV_W-1:0];
    if (wr_en && off == 3'd4) divt_d = din[DIV_W-1:0];
  end

  // Bit length is latched at each boundary so divisor writes never stretch a bit.
  assign tx_cnt_n = {1'b0, tx_cnt_q} + 1'b1;
  assign tx_end   = tx_cnt_n >= {1'b0, tx_div_q};

  always_comb begin
    tx_st_d  = tx_st_q;
    tx_cnt_d = tx_cnt_q;
    tx_div_d = tx_div_q;
    tx_bit_d = tx_bit_q;
    tx_sh_d  = tx_sh_q;
    txd_d    = txd_q;
    if (tx_st_q != TX_IDLE) begin
      tx_cnt_d = tx_end ? '0 : tx_cnt_q + 1'b1;
      if (tx_end) tx_div_d = divt_q;
    end
    unique case (tx_st_q)
      TX_IDLE: begin
        if (wr_en && off == 3'd0) begin
          tx_st_d  = TX_START;
          tx_sh_d  = din[7:0];
          tx_cnt_d = '0;
          tx_div_d = divt_q;
          txd_d    = 1'b0;
        end
      end
      TX_START: begin
        if (tx_end) begin
          tx_st_d  = TX_DATA;
          tx_bit_d = 3'd0;
          txd_d    = tx_sh_q[0];
        end
      end
      TX_DATA: begin
        if (tx_end) begin
          tx_sh_d = tx_sh_q >> 1;
          if (tx_bit_q == 3'd7) begin
            tx_st_d = TX_STOP;
            txd_d   = 1'b1;
          end else begin
            tx_bit_d = tx_bit_q + 1'b1;
            txd_d    = tx_sh_q[1];
          end
        end
      end
      TX_STOP: begin
        if (tx_end) tx_st_d = TX_IDLE;
      end
      default: tx_st_d = TX_IDLE;
    endcase
  end

  assign rx_cnt_n = {1'b0, rx_cnt_q} + 1'b1;
  assign rx_end   = rx_cnt_n >= {1'b0, rx_div_q};
  assign rx_mid   = rx_cnt_q >= {1'b0, rx_div_q[DIV_W-1:1]};

  always_comb begin
    rx_st_d   = rx_st_q;
    rx_cnt_d  = rx_cnt_q;
    rx_div_d  = rx_div_q;
    rx_bit_d  = rx_bit_q;
    rx_sh_d   = rx_sh_q;
    rx_byte_d = rx_byte_q;
    dr_d      = dr_q;
    fe_d      = fe_q;
    // A completing byte on the same edge as a DATA read must win.
    if (rd_data) begin
      dr_d = 1'b0;
      fe_d = 1'b0;
    end
    unique case (rx_st_q)
      RX_IDLE: begin
        if (!rx_s2_q) begin
          rx_st_d  = RX_START;
          rx_cnt_d = DIV_W'(1);
          rx_div_d = divr_q;
        end
      end
      RX_START: begin
        if (rx_mid) begin
          rx_cnt_d = '0;
          rx_bit_d = 3'd0;
          rx_st_d  = rx_s2_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_end) begin
          rx_cnt_d = '0;
          rx_sh_d  = {rx_s2_q, rx_sh_q[7:1]};
          if (rx_bit_q == 3'd7) rx_st_d = RX_STOP;
          else rx_bit_d = rx_bit_q + 1'b1;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_end) begin
          rx_cnt_d  = '0;
          rx_byte_d = rx_sh_q;
          dr_d      = 1'b1;
          fe_d      = ~rx_s2_q;
          rx_st_d   = rx_s2_q ? RX_IDLE : RX_WAIT;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_WAIT: begin
        if (rx_s2_q) rx_st_d = RX_IDLE;
      end
      default: rx_st_d = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      divr_q    <= DIV_INIT;
      divt_q    <= DIV_INIT;
      tx_st_q   <= TX_IDLE;
      tx_cnt_q  <= '0;
      tx_div_q  <= DIV_INIT;
      tx_bit_q  <= '0;
      tx_sh_q   <= '0;
      txd_q     <= 1'b1;
      rx_s1_q   <= 1'b1;
      rx_s2_q   <= 1'b1;
      rx_st_q   <= RX_IDLE;
      rx_cnt_q  <= '0;
      rx_div_q  <= DIV_INIT;
      rx_bit_q  <= '0;
      rx_sh_q   <= '0;
      rx_byte_q <= '0;
      dr_q      <= 1'b0;
      fe_q      <= 1'b0;
    end else begin
      divr_q    <= divr_d;
      divt_q    <= divt_d;
      tx_st_q   <= tx_st_d;
      tx_cnt_q  <= tx_cnt_d;
      tx_div_q  <= tx_div_d;
      tx_bit_q  <= tx_bit_d;
      tx_sh_q   <= tx_sh_d;
      txd_q     <= txd_d;
      rx_s1_q   <= rxd;
      rx_s2_q   <= rx_s1_q;
      rx_st_q   <= rx_st_d;
      rx_cnt_q  <= rx_cnt_d;
      rx_div_q  <= rx_div_d;
      rx_bit_q  <= rx_bit_d;
      rx_sh_q   <= rx_sh_d;
      rx_byte_q <= rx_byte_d;
      dr_q      <= dr_d;
      fe_q      <= fe_d;
    end
  end

endmodule

// File: tb/tb_mini_uart.sv
// tb_mini_uart: randomized self-checking bench for mini_uart
// against a frame-level behavioural model.
module tb_mini_uart;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  off = '0;
  logic [31:0] din = '0;
  logic [31:0] dout;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic        ack;
  logic        rxd = 1'b1;
  logic        txd;
  logic        irq;

  int checks = 0;
  int passes = 0;
  bit exp_dr = 1'b0;
  bit exp_fe = 1'b0;

  always #5 clk = ~clk;

  mini_uart #(.DIV_RST(434), .DIV_W(16)) dut (
    .clk(clk), .rst(rst), .off(off), .din(din), .dout(dout),
    .stb(stb), .we(we), .ack(ack), .rxd(rxd), .txd(txd),
    .IRQ_data_complete(irq)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  function automatic logic [31:0] exp_lsr(bit thr);
    return (thr ? 32 : 0) + (exp_fe ? 8 : 0) + (exp_dr ? 1 : 0);
  endfunction

  // Serial frame: index 0 start, 1..8 data LSB first, 9 stop.
  function automatic bit frame_bit(logic [7:0] b, int i);
    if (i == 0) return 1'b0;
    if (i >= 9) return 1'b1;
    return b[i-1];
  endfunction

  task automatic bus_write(input logic [2:0] o, input logic [31:0] d);
    @(negedge clk);
    stb = 1'b1; we = 1'b1; off = o; din = d;
    @(negedge clk);
    stb = 1'b0; we = 1'b0; off = '0; din = '0;
  endtask

  task automatic bus_read(input logic [2:0] o, output logic [31:0] d,
                          output logic a);
    @(negedge clk);
    stb = 1'b1; we = 1'b0; off = o;
    #1;
    d = dout;
    a = ack;
    @(negedge clk);
    stb = 1'b0; off = '0;
  endtask

  task automatic drive_rx(input logic [7:0] b, input int div, input bit stop);
    for (int i = 0; i < 10; i++) begin
      rxd = (i == 9) ? stop : frame_bit(b, i);
      repeat (div) @(negedge clk);
    end
    rxd = 1'b1;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic a;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (txd !== 1'b1) $display("FAIL reset_txd: got %b want 1", txd);
    else passes++;
    checks++;
    if (irq !== 1'b0) $display("FAIL reset_irq: got %b want 0", irq);
    else passes++;
    rst = 1'b0;
    bus_read(3'd2, d, a);
    checks++;
    if (d !== exp_lsr(1)) $display("FAIL reset_lsr: got %h want %h", d, exp_lsr(1));
    else passes++;
    checks++;
    if (a !== 1'b1) $display("FAIL reset_ack: got %b want 1", a);
    else passes++;
    bus_read(3'd3, d, a);
    checks++;
    if (d !== 32'd434) $display("FAIL reset_divr: got %0d want 434", d);
    else passes++;
    bus_read(3'd4, d, a);
    checks++;
    if (d !== 32'd434) $display("FAIL reset_divt: got %0d want 434", d);
    else passes++;
    bus_read(3'd0, d, a);
    checks++;
    if (d !== 32'd0) $display("FAIL reset_rxbyte: got %h want 0", d);
    else passes++;
    stb = 1'b0; off = 3'd2;
    #1;
    checks++;
    if (dout !== 32'd0 || ack !== 1'b0)
      $display("FAIL idle_bus: got dout=%h ack=%b want 0/0", dout, ack);
    else passes++;
    off = '0;
  endtask

  task automatic test_divisors();
    logic [31:0] d;
    logic a;
    logic [2:0] um [4];
    um[0] = 3'd1; um[1] = 3'd5; um[2] = 3'd6; um[3] = 3'd7;
    bus_write(3'd4, 32'd8);
    bus_write(3'd3, 32'd8);
    for (int i = 0; i < 4; i++) bus_write(um[i], 32'hFFFF_FFFF);
    bus_read(3'd3, d, a);
    checks++;
    if (d !== 32'd8) $display("FAIL divr_rb: got %0d want 8", d);
    else passes++;
    bus_read(3'd4, d, a);
    checks++;
    if (d !== 32'd8) $display("FAIL divt_rb: got %0d want 8", d);
    else passes++;
    for (int i = 0; i < 4; i++) begin
      bus_read(um[i], d, a);
      checks++;
      if (d !== 32'd0) $display("FAIL unmapped_%0d: got %h want 0", um[i], d);
      else passes++;
    end
  endtask

  task automatic test_tx(input logic [7:0] b, input int div, input bit busy);
    logic [31:0] d;
    logic [31:0] lsr0;
    logic a;
    int errs, first, idle_errs;
    errs = 0; first = -1; idle_errs = 0; lsr0 = '0;
    bus_write(3'd4, 32'(div));
    bus_write(3'd0, {24'b0, b});
    for (int k = 0; k < 10 * div; k++) begin
      stb = 1'b0; we = 1'b0; off = '0; din = '0;
      if (k == 0) begin stb = 1'b1; off = 3'd2; end
      if (busy && k == 3 * div + 2) begin
        stb = 1'b1; we = 1'b1; off = 3'd0; din = {24'b0, ~b};
      end
      #1;
      if (k == 0) lsr0 = dout;
      if (txd !== frame_bit(b, k / div)) begin
        errs++;
        if (first < 0) first = k;
      end
      @(negedge clk);
    end
    stb = 1'b0; we = 1'b0; din = '0;
    checks++;
    if (lsr0 !== exp_lsr(0))
      $display("FAIL tx_busy_lsr: got %h want %h", lsr0, exp_lsr(0));
    else passes++;
    checks++;
    if (errs != 0)
      $display("FAIL tx_frame %h div %0d: %0d bad clocks, first at %0d", b, div, errs, first);
    else passes++;
    for (int k = 0; k < 2 * div; k++) begin
      if (txd !== 1'b1) idle_errs++;
      @(negedge clk);
    end
    checks++;
    if (idle_errs != 0) $display("FAIL tx_idle: got %0d low clocks want 0", idle_errs);
    else passes++;
    bus_read(3'd2, d, a);
    checks++;
    if (d !== exp_lsr(1)) $display("FAIL tx_done_lsr: got %h want %h", d, exp_lsr(1));
    else passes++;
  endtask

  task automatic test_rx(input logic [7:0] b, input int div);
    logic [31:0] d;
    logic a;
    bus_write(3'd3, 32'(div));
    drive_rx(b, div, 1'b1);
    repeat (4) @(negedge clk);
    exp_dr = 1'b1; exp_fe = 1'b0;
    checks++;
    if (irq !== 1'b1) $display("FAIL rx_irq %h: got %b want 1", b, irq);
    else passes++;
    bus_read(3'd2, d, a);
    checks++;
    if (d !== exp_lsr(1)) $display("FAIL rx_lsr %h: got %h want %h", b, d, exp_lsr(1));
    else passes++;
    bus_read(3'd0, d, a);
    exp_dr = 1'b0;
    checks++;
    if (d !== {24'b0, b}) $display("FAIL rx_data: got %h want %h", d, b);
    else passes++;
    checks++;
    if (irq !== 1'b0) $display("FAIL rx_irq_clr: got %b want 0", irq);
    else passes++;
    bus_read(3'd2, d, a);
    checks++;
    if (d !== exp_lsr(1)) $display("FAIL rx_lsr_clr: got %h want %h", d, exp_lsr(1));
    else passes++;
  endtask

  task automatic test_framing();
    logic [31:0] d;
    logic a;
    bus_write(3'd3, 32'd8);
    rxd = 1'b0;
    repeat (12 * 8) @(negedge clk);
    exp_dr = 1'b1; exp_fe = 1'b1;
    checks++;
    if (irq !== 1'b1) $display("FAIL fe_irq: got %b want 1", irq);
    else passes++;
    bus_read(3'd2, d, a);
    checks++;
    if (d !== exp_lsr(1)) $display("FAIL fe_lsr: got %h want %h", d, exp_lsr(1));
    else passes++;
    bus_read(3'd0, d, a);
    exp_dr = 1'b0; exp_fe = 1'b0;
    checks++;
    if (d !== 32'd0) $display("FAIL fe_data: got %h want 0", d);
    else passes++;
    repeat (40) @(negedge clk);
    checks++;
    if (irq !== 1'b0) $display("FAIL fe_hold_irq: got %b want 0", irq);
    else passes++;
    bus_read(3'd2, d, a);
    checks++;
    if (d !== exp_lsr(1)) $display("FAIL fe_hold_lsr: got %h want %h", d, exp_lsr(1));
    else passes++;
    rxd = 1'b1;
    repeat (16) @(negedge clk);
    test_rx(8'($urandom_range(0, 255)), 8);
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    logic a;
    logic [7:0] b1, b2;
    b1 = 8'($urandom_range(0, 255));
    b2 = 8'($urandom_range(0, 255));
    bus_write(3'd3, 32'd8);
    drive_rx(b1, 8, 1'b1);
    drive_rx(b2, 8, 1'b1);
    repeat (4) @(negedge clk);
    exp_dr = 1'b1; exp_fe = 1'b0;
    bus_read(3'd2, d, a);
    checks++;
    if (d !== exp_lsr(1)) $display("FAIL ovr_lsr: got %h want %h", d, exp_lsr(1));
    else passes++;
    bus_read(3'd0, d, a);
    exp_dr = 1'b0;
    checks++;
    if (d !== {24'b0, b2}) $display("FAIL ovr_data: got %h want %h", d, b2);
    else passes++;
  endtask

  task automatic test_reset_mid_tx();
    logic [31:0] d;
    logic a;
    bus_write(3'd4, 32'd8);
    bus_write(3'd0, 32'h00);
    repeat (20) @(negedge clk);
    #1;
    checks++;
    if (txd !== 1'b0) $display("FAIL midtx_low: got %b want 0", txd);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1) $display("FAIL rst_txd: got %b want 1", txd);
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    exp_dr = 1'b0; exp_fe = 1'b0;
    bus_read(3'd2, d, a);
    checks++;
    if (d !== exp_lsr(1)) $display("FAIL rst_lsr: got %h want %h", d, exp_lsr(1));
    else passes++;
    bus_read(3'd3, d, a);
    checks++;
    if (d !== 32'd434) $display("FAIL rst_divr: got %0d want 434", d);
    else passes++;
    bus_read(3'd4, d, a);
    checks++;
    if (d !== 32'd434) $display("FAIL rst_divt: got %0d want 434", d);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_divisors();
    test_tx(8'h37, 8, 1'b1);
    for (int i = 0; i < 3; i++)
      test_tx(8'($urandom_range(0, 255)), int'($urandom_range(6, 12)), 1'b0);
    test_rx(8'hA5, 8);
    for (int i = 0; i < 3; i++)
      test_rx(8'($urandom_range(0, 255)), int'($urandom_range(6, 12)));
    test_framing();
    test_back_to_back();
    test_reset_mid_tx();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
